seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/cpu_pkg.sv | 6 +
 rtl/seq_divider_if.sv | 14 +
 rtl/div_step.sv | 18 +
 rtl/seq_divider.sv | 86 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath width, divider state encoding and ALU opcodes
package cpu_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [3:0] ALU_DIV = 4'd12;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between the CPU control and the sequential divider
interface seq_divider_if;
  import cpu_pkg::*;
  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  modport master (output start, dividend, divisor, input quotient, remainder, busy, done, div_by_zero);
  modport slave (input start, dividend, divisor, output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on a 33-bit partial remainder
module div_step
  import cpu_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem,
  input  logic [DIV_WIDTH-1:0] quo,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH:0]   rem_next,
  output logic [DIV_WIDTH-1:0] quo_next
);
  logic [DIV_WIDTH+1:0] shifted, diff;
  always_comb begin
    shifted  = {rem, quo[DIV_WIDTH-1]};
    diff     = shifted - {2'b00, dvs};
    rem_next = diff[DIV_WIDTH+1] ? shifted[DIV_WIDTH:0] : diff[DIV_WIDTH:0];
    quo_next = {quo[DIV_WIDTH-2:0], ~diff[DIV_WIDTH+1]};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: 32-cycle restoring divider; define DIV_SIGNED_EN for two's-complement operands
module seq_divider
  import cpu_pkg::*;
(
  input  logic         clock,
  input  logic         clear_n,
  seq_divider_if.slave bus
);
  div_state_t           state;
  logic [DIV_WIDTH:0]   rem, rem_next;
  logic [DIV_WIDTH-1:0] quo, quo_next, dvs, a_mag, b_mag, quotient, remainder;
  logic [5:0]           cnt;
  logic                 neg_q, neg_r, q_neg_in, r_neg_in, busy, done, dbz;
`ifdef DIV_SIGNED_EN
  assign a_mag    = bus.dividend[DIV_WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_mag    = bus.divisor[DIV_WIDTH-1] ? -bus.divisor : bus.divisor;
  assign q_neg_in = bus.dividend[DIV_WIDTH-1] ^ bus.divisor[DIV_WIDTH-1];
  assign r_neg_in = bus.dividend[DIV_WIDTH-1];
`else
  assign a_mag    = bus.dividend;
  assign b_mag    = bus.divisor;
  assign q_neg_in = 1'b0;
  assign r_neg_in = 1'b0;
`endif
  div_step u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_next(rem_next), .quo_next(quo_next));
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start && bus.divisor != '0) begin
          state <= RUN;
          busy  <= 1'b1;
          rem   <= '0;
          quo   <= a_mag;
          dvs   <= b_mag;
          cnt   <= '0;
          neg_q <= q_neg_in;
          neg_r <= r_neg_in;
          dbz   <= 1'b0;
        end else if (bus.start) begin
          state     <= DONE;
          busy      <= 1'b1;
          done      <= 1'b1;
          quotient  <= '1;
          remainder <= bus.dividend;
          dbz       <= 1'b1;
        end
        RUN: begin
          rem   <= rem_next;
          quo   <= quo_next;
          cnt   <= cnt + 6'd1;
          state <= cnt == 6'd31 ? FIX : RUN;
        end
        // quotient magnitude of 2^31 negates onto itself, giving the MIN/-1 result for free
        FIX: begin
          quotient  <= neg_q ? -quo : quo;
          remainder <= neg_r ? -rem[DIV_WIDTH-1:0] : rem[DIV_WIDTH-1:0];
          done      <= 1'b1;
          state     <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dbz;
endmodule
